// File: rtl/register_bank_pkg.sv
// Shared types and constants for the register bank.
package register_pkg;

    typedef enum logic {
        REG_IDLE,
        REG_CLEAR
    } register_state_t;

    localparam int REGISTER_DATA_WIDTH = 16;

endpackage

// File: rtl/register_bank_if.sv
// Bus-side signal bundle of the register bank; the slave modport is the bank itself.
interface register_bank_if
    import register_pkg::*;
#(
    parameter int DATA_WIDTH = REGISTER_DATA_WIDTH,
    parameter int REG_COUNT  = 4
) ();
    localparam int ADDR_WIDTH = $clog2(REG_COUNT);

    // Strobes are level-sampled on each rising edge: bus_register_input_en writes on that
    // edge, bus_register_out_en requests data that is driven for the whole next cycle,
    // register_clear_start is a one-cycle pulse and is ignored while register_busy=1.
    logic [DATA_WIDTH-1:0] bus_register_input;
    logic                  bus_register_input_en;
    logic [ADDR_WIDTH-1:0] register_write_addr;
    logic [ADDR_WIDTH-1:0] register_read_addr_a;
    logic [ADDR_WIDTH-1:0] register_read_addr_b;
    logic [DATA_WIDTH-1:0] register_read_data_a;
    logic [DATA_WIDTH-1:0] register_read_data_b;
    logic [ADDR_WIDTH-1:0] bus_register_read_addr;
    logic                  bus_register_out_en;
    wire  [DATA_WIDTH-1:0] bus_register_output;
    logic                  register_clear_start;
    logic                  register_busy;
    register_state_t       register_state_dbg;
    logic                  bus_register_drive_dbg;

    modport master (
        output bus_register_input, bus_register_input_en, register_write_addr,
        output register_read_addr_a, register_read_addr_b,
        output bus_register_read_addr, bus_register_out_en, register_clear_start,
        input  register_read_data_a, register_read_data_b, bus_register_output,
        input  register_busy, register_state_dbg, bus_register_drive_dbg
    );

    modport slave (
        input  bus_register_input, bus_register_input_en, register_write_addr,
        input  register_read_addr_a, register_read_addr_b,
        input  bus_register_read_addr, bus_register_out_en, register_clear_start,
        output register_read_data_a, register_read_data_b, bus_register_output,
        output register_busy, register_state_dbg, bus_register_drive_dbg
    );

endinterface

// File: rtl/register_bank_tri_state_buffer.sv
// Tri-state driver: passes data_i when enable_i is high, floats otherwise.
module tri_state_buffer #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             enable_i,
    output wire  [WIDTH-1:0] data_o
);
    assign data_o = enable_i ? data_i : {WIDTH{1'bz}};
endmodule

// File: rtl/register_bank.sv
// WIDTH x DEPTH register file with two combinational read ports, a registered tri-stated
// bus read port and a one-register-per-cycle clear engine. Optional macro: REGISTER_BYPASS_EN.
module register_bank
    import register_pkg::*;
#(
    parameter int DATA_WIDTH = REGISTER_DATA_WIDTH,
    parameter int REG_COUNT  = 4
) (
    input  logic           register_clock,
    input  logic           register_reset,
    register_bank_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(REG_COUNT);

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    localparam addr_t LAST_ADDR = addr_t'(REG_COUNT - 1);

    data_t           regs_q [REG_COUNT];
    register_state_t state_q;
    addr_t           clear_cnt_q;
    logic            busy_q;
    data_t           bus_data_q;
    data_t           bus_data_d;
    logic            bus_drive_q;
    logic            write_fire;
    data_t           read_a;
    data_t           read_b;

    function automatic logic in_range(addr_t a);
        return int'(a) < REG_COUNT;
    endfunction

    function automatic data_t stored(addr_t a);
        return in_range(a) ? regs_q[a] : '0;
    endfunction

    // Every read path sees the same view, so bypass applies to A, B and the bus alike.
    function automatic data_t port_view(addr_t a);
`ifdef REGISTER_BYPASS_EN
        if (write_fire && (bus.register_write_addr == a)) begin
            return bus.bus_register_input;
        end
`endif
        return stored(a);
    endfunction

    assign write_fire = bus.bus_register_input_en && (state_q == REG_IDLE)
                        && in_range(bus.register_write_addr);

    always_comb begin
        read_a     = port_view(bus.register_read_addr_a);
        read_b     = port_view(bus.register_read_addr_b);
        bus_data_d = bus.bus_register_out_en ? port_view(bus.bus_register_read_addr) : bus_data_q;
    end

    always_ff @(posedge register_clock or posedge register_reset) begin
        if (register_reset) begin
            state_q     <= REG_IDLE;
            clear_cnt_q <= '0;
            busy_q      <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                REG_IDLE: begin
                    // A write on the start edge still commits; the sweep zeroes it later.
                    if (write_fire) begin
                        regs_q[bus.register_write_addr] <= bus.bus_register_input;
                    end
                    if (bus.register_clear_start) begin
                        state_q     <= REG_CLEAR;
                        clear_cnt_q <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                REG_CLEAR: begin
                    regs_q[clear_cnt_q] <= '0;
                    clear_cnt_q         <= clear_cnt_q + 1'b1;
                    if (clear_cnt_q == LAST_ADDR) begin
                        state_q <= REG_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= REG_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge register_clock or posedge register_reset) begin
        if (register_reset) begin
            bus_data_q  <= '0;
            bus_drive_q <= 1'b0;
        end else begin
            bus_data_q  <= bus_data_d;
            bus_drive_q <= bus.bus_register_out_en;
        end
    end

    tri_state_buffer #(
        .WIDTH(DATA_WIDTH)
    ) u_bus_drive (
        .data_i  (bus_data_q),
        .enable_i(bus_drive_q),
        .data_o  (bus.bus_register_output)
    );

    assign bus.register_read_data_a   = read_a;
    assign bus.register_read_data_b   = read_b;
    assign bus.register_busy          = busy_q;
    assign bus.register_state_dbg     = state_q;
    assign bus.bus_register_drive_dbg = bus_drive_q;

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: a 4x16 instance tracked by a behavioural model
// every cycle, plus a 5x8 instance exercised with directed literal checks.
module tb_register_bank;
    import register_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    register_bank_if #(.DATA_WIDTH(16), .REG_COUNT(4)) bif ();
    register_bank_if #(.DATA_WIDTH(8), .REG_COUNT(5)) bif2 ();

    register_bank #(.DATA_WIDTH(16), .REG_COUNT(4)) dut (
        .register_clock(clk),
        .register_reset(rst),
        .bus           (bif.slave)
    );

    register_bank #(.DATA_WIDTH(8), .REG_COUNT(5)) dut2 (
        .register_clock(clk),
        .register_reset(rst2),
        .bus           (bif2.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model of the 4x16 instance ----------------
    logic [15:0] m_regs [4];
    int          m_clear_left;
    int          m_clear_next;
    logic        m_drive;
    logic [15:0] m_bus;

    function automatic logic [15:0] m_view(logic [1:0] a);
`ifdef REGISTER_BYPASS_EN
        if (bif.bus_register_input_en && m_clear_left == 0 && bif.register_write_addr == a)
            return bif.bus_register_input;
`endif
        return m_regs[a];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 16'h0;
            m_clear_left = 0;
            m_clear_next = 0;
            m_drive = 1'b0;
            m_bus = 16'h0;
        end else begin
            if (bif.bus_register_out_en) m_bus = m_view(bif.bus_register_read_addr);
            m_drive = bif.bus_register_out_en;
            if (m_clear_left == 0) begin
                if (bif.bus_register_input_en) m_regs[bif.register_write_addr] = bif.bus_register_input;
                if (bif.register_clear_start) begin
                    m_clear_left = 4;
                    m_clear_next = 0;
                end
            end else begin
                m_regs[m_clear_next] = 16'h0;
                m_clear_next++;
                m_clear_left--;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cmp_port_a", 32'(bif.register_read_data_a), 32'(m_view(bif.register_read_addr_a)));
            check("cmp_port_b", 32'(bif.register_read_data_b), 32'(m_view(bif.register_read_addr_b)));
            check("cmp_busy", 32'(bif.register_busy), 32'(m_clear_left != 0));
            check("cmp_state", 32'(bif.register_state_dbg == REG_CLEAR), 32'(m_clear_left != 0));
            check("cmp_drive", 32'(bif.bus_register_drive_dbg), 32'(m_drive));
            if (m_drive) check("cmp_bus", 32'(bif.bus_register_output), 32'(m_bus));
        end
    end

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        bif.bus_register_input_en = 1'b1;
        bif.register_write_addr = a;
        bif.bus_register_input = d;
        tick();
        bif.bus_register_input_en = 1'b0;
    endtask

    task automatic wr2(input logic [2:0] a, input logic [7:0] d);
        bif2.bus_register_input_en = 1'b1;
        bif2.register_write_addr = a;
        bif2.bus_register_input = d;
        tick();
        bif2.bus_register_input_en = 1'b0;
    endtask

    initial begin
        int cycles;
        logic [15:0] collide_exp;
`ifdef REGISTER_BYPASS_EN
        collide_exp = 16'hBEEF;
`else
        collide_exp = 16'h0001;
`endif
        bif.bus_register_input = '0;  bif.bus_register_input_en = 1'b0;
        bif.register_write_addr = '0; bif.register_read_addr_a = '0;
        bif.register_read_addr_b = '0; bif.bus_register_read_addr = '0;
        bif.bus_register_out_en = 1'b0; bif.register_clear_start = 1'b0;
        bif2.bus_register_input = '0;  bif2.bus_register_input_en = 1'b0;
        bif2.register_write_addr = '0; bif2.register_read_addr_a = '0;
        bif2.register_read_addr_b = '0; bif2.bus_register_read_addr = '0;
        bif2.bus_register_out_en = 1'b0; bif2.register_clear_start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rst2 = 1'b0;
        #1;
        check("reset_busy", 32'(bif.register_busy), 32'h0);
        check("reset_drive", 32'(bif.bus_register_drive_dbg), 32'h0);
        check("reset_port_a", 32'(bif.register_read_data_a), 32'h0);

        // basic writes and dual-port read
        tick();
        wr(2'd2, 16'hA5A5);
        wr(2'd3, 16'h1234);
        bif.register_read_addr_a = 2'd2;
        bif.register_read_addr_b = 2'd3;
        #1;
        check("dual_read_a", 32'(bif.register_read_data_a), 32'hA5A5);
        check("dual_read_b", 32'(bif.register_read_data_b), 32'h1234);
        check("bus_z_before", 32'(bif.bus_register_drive_dbg), 32'h0);
        bif.bus_register_out_en = 1'b1;
        bif.bus_register_read_addr = 2'd3;
        tick();
        bif.bus_register_out_en = 1'b0;
        check("bus_read_drive", 32'(bif.bus_register_drive_dbg), 32'h1);
        check("bus_read_data", 32'(bif.bus_register_output), 32'h1234);
        tick();
        check("bus_z_after", 32'(bif.bus_register_drive_dbg), 32'h0);

        // write / read collision on the same edge
        wr(2'd1, 16'h0001);
        bif.bus_register_input_en = 1'b1;
        bif.register_write_addr = 2'd1;
        bif.bus_register_input = 16'hBEEF;
        bif.bus_register_out_en = 1'b1;
        bif.bus_register_read_addr = 2'd1;
        bif.register_read_addr_a = 2'd1;
        #1;
        check("collide_port_a", 32'(bif.register_read_data_a), 32'(collide_exp));
        tick();
        bif.bus_register_input_en = 1'b0;
        bif.bus_register_out_en = 1'b0;
        check("collide_bus", 32'(bif.bus_register_output), 32'(collide_exp));
        check("collide_commit", 32'(bif.register_read_data_a), 32'hBEEF);

        // back-to-back bus reads of 0,1,2
        wr(2'd0, 16'h1111);
        bif.bus_register_out_en = 1'b1;
        bif.bus_register_read_addr = 2'd0;
        tick();
        check("b2b_0", 32'(bif.bus_register_output), 32'h1111);
        bif.bus_register_read_addr = 2'd1;
        tick();
        check("b2b_1", 32'(bif.bus_register_output), 32'hBEEF);
        bif.bus_register_read_addr = 2'd2;
        tick();
        check("b2b_2", 32'(bif.bus_register_output), 32'hA5A5);
        bif.bus_register_out_en = 1'b0;
        tick();
        check("b2b_z", 32'(bif.bus_register_drive_dbg), 32'h0);

        // clear sequence with a dropped write and an ignored restart
        for (int i = 0; i < 4; i++) wr(2'(i), 16'hFFFF);
        bif.register_clear_start = 1'b1;
        tick();
        bif.register_clear_start = 1'b0;
        cycles = 0;
        while (bif.register_busy && cycles < 20) begin
            cycles++;
            bif.bus_register_input_en = (cycles == 1);
            bif.register_clear_start = (cycles == 1);
            bif.register_write_addr = 2'd0;
            bif.bus_register_input = 16'h5555;
            bif.register_read_addr_a = 2'(cycles - 1);
            bif.register_read_addr_b = 2'(cycles);
            tick();
            bif.bus_register_input_en = 1'b0;
            bif.register_clear_start = 1'b0;
            check("clear_order_zero", 32'(bif.register_read_data_a), 32'h0);
            if (cycles < 4) check("clear_order_pending", 32'(bif.register_read_data_b), 32'hFFFF);
        end
        check("clear_cycles", 32'(cycles), 32'd4);
        tick();
        check("clear_no_restart", 32'(bif.register_busy), 32'h0);

        // asynchronous reset in the middle of a clear
        for (int i = 0; i < 4; i++) wr(2'(i), 16'hFFFF);
        bif.bus_register_out_en = 1'b1;
        bif.bus_register_read_addr = 2'd3;
        bif.register_clear_start = 1'b1;
        tick();
        bif.register_clear_start = 1'b0;
        tick();
        bif.register_read_addr_a = 2'd2;
        bif.register_read_addr_b = 2'd3;
        #1;
        check("midclear_pre", 32'(bif.register_read_data_b), 32'hFFFF);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_a", 32'(bif.register_read_data_a), 32'h0);
        check("async_rst_b", 32'(bif.register_read_data_b), 32'h0);
        check("async_rst_busy", 32'(bif.register_busy), 32'h0);
        check("async_rst_drive", 32'(bif.bus_register_drive_dbg), 32'h0);
        bif.bus_register_out_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // 5 x 8 instance: out-of-range addresses and a 5-cycle clear
        tick();
        wr2(3'd4, 8'h7F);
        wr2(3'd6, 8'h55);
        bif2.register_read_addr_a = 3'd4;
        bif2.register_read_addr_b = 3'd6;
        #1;
        check("r5_addr4", 32'(bif2.register_read_data_a), 32'h7F);
        check("r5_addr6", 32'(bif2.register_read_data_b), 32'h00);
        bif2.register_read_addr_b = 3'd2;
        #1;
        check("r5_no_alias", 32'(bif2.register_read_data_b), 32'h00);
        bif2.bus_register_out_en = 1'b1;
        bif2.bus_register_read_addr = 3'd4;
        tick();
        check("r5_bus4", 32'(bif2.bus_register_output), 32'h7F);
        bif2.bus_register_read_addr = 3'd6;
        tick();
        bif2.bus_register_out_en = 1'b0;
        check("r5_bus6", 32'(bif2.bus_register_output), 32'h00);
        bif2.register_clear_start = 1'b1;
        tick();
        bif2.register_clear_start = 1'b0;
        cycles = 0;
        while (bif2.register_busy && cycles < 20) begin
            cycles++;
            tick();
        end
        check("r5_clear_cycles", 32'(cycles), 32'd5);
        check("r5_cleared", 32'(bif2.register_read_data_a), 32'h00);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
